hpc_rand_feeder: RTL and testbench

- Fresh-randomness source that sits directly upstream of the HPC masked AND gadgets.
- Supplies RAND_W fresh bits per accepted cycle to a gadget's p_rand_* inputs.
- Built on a 64-bit Fibonacci LFSR, unrolled to RAND_W steps per cycle.
- Seeded through a 16-bit word handshake and gated by a warm-up phase, so a gadget never consumes stale or unseeded randomness.

---
 rtl/hpc_rand_feeder_if.sv | 22 ++
 rtl/hpc_rand_feeder.sv | 136 +++++++++++++
 tb/tb_hpc_rand_feeder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/hpc_rand_feeder_if.sv
// Handshake bundle between a seed source / randomness consumer and the HPC rand feeder.
// The feeder sits on the slave side; the environment (seed source plus gadget) sits on the master side.
interface hpc_rand_feeder_if #(
    parameter int RAND_W = 20
) ();
    logic              seed_valid;
    logic              seed_ready;
    logic [15:0]       seed_word;
    logic              rand_valid;
    logic              rand_ready;
    logic [RAND_W-1:0] rand_out;

    modport master (
        output seed_valid, seed_word, rand_ready,
        input  seed_ready, rand_valid, rand_out
    );

    modport slave (
        input  seed_valid, seed_word, rand_ready,
        output seed_ready, rand_valid, rand_out
    );
endinterface

// File: rtl/hpc_rand_feeder.sv
// Fresh-randomness source for HPC masked AND gadgets: a 64-bit Fibonacci LFSR unrolled RAND_W steps per
// advance, seeded through four 16-bit words and held back by a warm-up phase before any bit is exposed.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------------
//   ST_SEED   | collecting seed words k=0..3 into s, no randomness exposed
//   ST_WARMUP | discarding WARMUP advances after a seed load, seed input blocked
//   ST_RUN    | first cycle loads rand_out, then one advance per accepted word
module hpc_rand_feeder #(
    parameter int RAND_W = 20,
    parameter int WARMUP = 8
) (
    input  logic              clock_0,
    input  logic              reset_0,
    hpc_rand_feeder_if.slave  bus,
    output logic              busy,
    output logic              err_zero_seed
);
    localparam int WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t             r_state;
    logic [63:0]        r_s;
    logic [1:0]         r_k;
    logic [WCNT_W-1:0]  r_wcnt;
    logic [RAND_W-1:0]  r_rand_out;
    logic               r_rand_valid;
    logic               r_seed_ready;
    logic               r_busy;
    logic               r_err;

    logic [63:0]        w_adv_s;
    logic [RAND_W-1:0]  w_adv_bits;
    logic               w_fb;
    logic [63:0]        w_seed_full;
    logic               w_seed_hs;

    // RAND_W single steps chained combinationally; bit i is the feedback of step i+1.
    always_comb begin
        w_adv_s    = r_s;
        w_adv_bits = '0;
        w_fb       = 1'b0;
        for (int i = 0; i < RAND_W; i++) begin
            w_fb          = w_adv_s[63] ^ w_adv_s[62] ^ w_adv_s[60] ^ w_adv_s[59];
            w_adv_bits[i] = w_fb;
            w_adv_s       = {w_adv_s[62:0], w_fb};
        end
    end

    assign w_seed_hs   = bus.seed_valid & r_seed_ready;
    assign w_seed_full = {bus.seed_word, r_s[47:0]};

    always_ff @(posedge clock_0 or negedge reset_0) begin
        if (!reset_0) begin
            r_state      <= ST_SEED;
            r_s          <= 64'h0;
            r_k          <= 2'd0;
            r_wcnt       <= '0;
            r_rand_out   <= '0;
            r_rand_valid <= 1'b0;
            r_seed_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_SEED: begin
                    if (w_seed_hs) begin
                        if (r_k == 2'd3) begin
                            r_k <= 2'd0;
                            // An all-zero LFSR would lock up; substitute 1 and flag it.
                            if (w_seed_full == 64'h0) begin
                                r_s   <= 64'h1;
                                r_err <= 1'b1;
                            end else begin
                                r_s <= w_seed_full;
                            end
                            if (WARMUP == 0) begin
                                r_state <= ST_RUN;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state      <= ST_WARMUP;
                                r_wcnt       <= WCNT_W'(WARMUP);
                                r_seed_ready <= 1'b0;
                            end
                        end else begin
                            r_s[{r_k, 4'b0000} +: 16] <= bus.seed_word;
                            r_k                       <= r_k + 2'd1;
                        end
                    end
                end
                ST_WARMUP: begin
                    r_s        <= w_adv_s;
                    r_rand_out <= w_adv_bits;
                    r_wcnt     <= r_wcnt - WCNT_W'(1);
                    if (r_wcnt == WCNT_W'(1)) begin
                        r_state      <= ST_RUN;
                        r_busy       <= 1'b0;
                        r_seed_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A reseed wins over a same-cycle consume: the word is neither advanced nor counted.
                    if (w_seed_hs) begin
                        r_s[15:0]    <= bus.seed_word;
                        r_k          <= 2'd1;
                        r_state      <= ST_SEED;
                        r_busy       <= 1'b1;
                        r_rand_valid <= 1'b0;
                    end else if (!r_rand_valid || bus.rand_ready) begin
                        r_s          <= w_adv_s;
                        r_rand_out   <= w_adv_bits;
                        r_rand_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_SEED;
                    r_k          <= 2'd0;
                    r_rand_valid <= 1'b0;
                    r_seed_ready <= 1'b1;
                    r_busy       <= 1'b1;
                end
            endcase
        end
    end

    assign bus.seed_ready = r_seed_ready;
    assign bus.rand_valid = r_rand_valid;
    assign bus.rand_out   = r_rand_out;
    assign busy           = r_busy;
    assign err_zero_seed  = r_err;
endmodule

// File: tb/tb_hpc_rand_feeder.sv
// Bench for hpc_rand_feeder: directed seed/stall/reseed flows on a WARMUP=0 instance and randomized
// episodes on a WARMUP=8 instance, both checked against a bit-stream reference of the LFSR.
module tb_hpc_rand_feeder;
    localparam int RAND_W = 20;
    localparam int WARM_A = 0;
    localparam int WARM_B = 8;

    logic clock_0 = 1'b0;
    logic reset_0 = 1'b0;
    always #5 clock_0 = ~clock_0;

    hpc_rand_feeder_if #(.RAND_W(RAND_W)) bus_a ();
    hpc_rand_feeder_if #(.RAND_W(RAND_W)) bus_b ();
    logic busy_a, err_a, busy_b, err_b;

    hpc_rand_feeder #(.RAND_W(RAND_W), .WARMUP(WARM_A)) u_dut_a (
        .clock_0       (clock_0),
        .reset_0       (reset_0),
        .bus           (bus_a.slave),
        .busy          (busy_a),
        .err_zero_seed (err_a)
    );

    hpc_rand_feeder #(.RAND_W(RAND_W), .WARMUP(WARM_B)) u_dut_b (
        .clock_0       (clock_0),
        .reset_0       (reset_0),
        .bus           (bus_b.slave),
        .busy          (busy_b),
        .err_zero_seed (err_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word n (1-based) of the output stream: the LFSR feedback bits numbered from step 1 after seeding,
    // cut into RAND_W-bit words with the earliest bit in bit 0. A zero seed behaves as seed 1.
    function automatic logic [RAND_W-1:0] ref_word(input logic [63:0] seed, input int n);
        logic [63:0]       s;
        logic [RAND_W-1:0] w;
        logic              fb;
        s = (seed == 64'h0) ? 64'h1 : seed;
        w = '0;
        for (int t = 1; t <= n * RAND_W; t++) begin
            fb = s[63] ^ s[62] ^ s[60] ^ s[59];
            s  = {s[62:0], fb};
            if (t > (n - 1) * RAND_W) w[t - (n - 1) * RAND_W - 1] = fb;
        end
        return w;
    endfunction

    // Drive seed words k0..3 into instance A; inputs change on negedges, handshakes happen on posedges.
    task automatic seed_a(input logic [63:0] seed, input int k0);
        logic [63:0] sv;
        sv = seed;
        for (int k = k0; k < 4; k++) begin
            bus_a.seed_word  = sv[16*k +: 16];
            bus_a.seed_valid = 1'b1;
            check("a_seed_ready", {63'h0, bus_a.seed_ready}, 64'h1);
            @(negedge clock_0);
        end
        bus_a.seed_valid = 1'b0;
    endtask

    // Seed instance B with idle gaps between words; rand_out must hold the last shown word meanwhile.
    task automatic seed_b(input logic [63:0] seed, input logic [RAND_W-1:0] hold);
        logic [63:0] sv;
        sv = seed;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    bus_b.seed_valid = 1'b0;
                    bus_b.rand_ready = 1'($urandom_range(0, 1));
                    @(negedge clock_0);
                end
            end
            bus_b.seed_word  = sv[16*k +: 16];
            bus_b.seed_valid = 1'b1;
            bus_b.rand_ready = 1'($urandom_range(0, 1));
            check("b_seed_ready", {63'h0, bus_b.seed_ready}, 64'h1);
            @(negedge clock_0);
            check("b_seed_no_valid", {63'h0, bus_b.rand_valid}, 64'h0);
            check("b_seed_busy", {63'h0, busy_b}, 64'h1);
            if (k < 3) check("b_seed_hold", 64'(bus_b.rand_out), 64'(hold));
        end
        bus_b.seed_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cur;
        logic [63:0] seed;
        logic [RAND_W-1:0] hold;
        logic        err_exp;
        logic        rdy;

        bus_a.seed_valid = 1'b0; bus_a.seed_word = '0; bus_a.rand_ready = 1'b0;
        bus_b.seed_valid = 1'b0; bus_b.seed_word = '0; bus_b.rand_ready = 1'b0;
        reset_0 = 1'b0;
        repeat (2) @(negedge clock_0);

        check("rst_a_seed_ready", {63'h0, bus_a.seed_ready}, 64'h1);
        check("rst_a_busy",       {63'h0, busy_a},           64'h1);
        check("rst_a_valid",      {63'h0, bus_a.rand_valid}, 64'h0);
        check("rst_a_out",        64'(bus_a.rand_out),       64'h0);
        check("rst_a_err",        {63'h0, err_a},            64'h0);
        check("rst_b_seed_ready", {63'h0, bus_b.seed_ready}, 64'h1);
        check("rst_b_busy",       {63'h0, busy_b},           64'h1);
        check("rst_b_valid",      {63'h0, bus_b.rand_valid}, 64'h0);
        reset_0 = 1'b1;
        @(negedge clock_0);

        // Zero seed on A, consumer always ready.
        bus_a.rand_ready = 1'b1;
        seed_a(64'h0, 0);
        check("zero_entry_valid", {63'h0, bus_a.rand_valid}, 64'h0);
        check("zero_entry_busy",  {63'h0, busy_a},           64'h0);
        check("zero_err",         {63'h0, err_a},            64'h1);
        cur = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock_0);
            check("zero_valid", {63'h0, bus_a.rand_valid}, 64'h1);
            check("zero_word",  64'(bus_a.rand_out), 64'(ref_word(64'h1, cur)));
            if (c < 5) cur++;
        end

        // Stall for 5 cycles on word 6, then take it.
        bus_a.rand_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock_0);
            check("stall_valid", {63'h0, bus_a.rand_valid}, 64'h1);
            check("stall_word",  64'(bus_a.rand_out), 64'(ref_word(64'h1, 6)));
        end
        bus_a.rand_ready = 1'b1;
        @(negedge clock_0);
        check("stall_next_word", 64'(bus_a.rand_out), 64'(ref_word(64'h1, 7)));
        check("zero_err_sticky", {63'h0, err_a}, 64'h1);

        // Asynchronous reset asserted mid-cycle.
        @(posedge clock_0);
        #3;
        reset_0 = 1'b0;
        #1;
        check("async_seed_ready", {63'h0, bus_a.seed_ready}, 64'h1);
        check("async_busy",       {63'h0, busy_a},           64'h1);
        check("async_valid",      {63'h0, bus_a.rand_valid}, 64'h0);
        check("async_out",        64'(bus_a.rand_out),       64'h0);
        check("async_err",        {63'h0, err_a},            64'h0);
        @(negedge clock_0);
        reset_0 = 1'b1;
        @(negedge clock_0);

        // Deterministic seed 1 with literal expected words.
        seed_a(64'h1, 0);
        check("det_entry_valid", {63'h0, bus_a.rand_valid}, 64'h0);
        check("det_err",         {63'h0, err_a},            64'h0);
        @(negedge clock_0);
        check("det_valid", {63'h0, bus_a.rand_valid}, 64'h1);
        check("det_w1", 64'(bus_a.rand_out), 64'h00000);
        @(negedge clock_0);
        check("det_w2", 64'(bus_a.rand_out), 64'h00000);
        @(negedge clock_0);
        check("det_w3", 64'(bus_a.rand_out), 64'h80000);

        // Reseed while the consumer is also ready: no advance, valid drops.
        bus_a.seed_word  = 16'h0001;
        bus_a.seed_valid = 1'b1;
        @(negedge clock_0);
        bus_a.seed_valid = 1'b0;
        check("reseed_valid", {63'h0, bus_a.rand_valid}, 64'h0);
        check("reseed_hold",  64'(bus_a.rand_out), 64'h80000);
        check("reseed_busy",  {63'h0, busy_a}, 64'h1);
        seed_a(64'h1, 1);
        check("reseed_entry_valid", {63'h0, bus_a.rand_valid}, 64'h0);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clock_0);
            check("reseed_valid_run", {63'h0, bus_a.rand_valid}, 64'h1);
            check("reseed_word", 64'(bus_a.rand_out), 64'(ref_word(64'h1, n)));
        end
        check("reseed_w3_literal", 64'(ref_word(64'h1, 3)), 64'(20'h80000));
        bus_a.rand_ready = 1'b0;

        // Randomized episodes on B (WARMUP=8): seeding, warm-up timing, random consume, reseed from RUN.
        hold    = '0;
        err_exp = 1'b0;
        for (int ep = 0; ep < 6; ep++) begin
            if (ep == 0)      seed = 64'h1;
            else if (ep == 2) seed = 64'h0;
            else              seed = {$urandom, $urandom};
            err_exp = err_exp | (seed == 64'h0);
            seed_b(seed, hold);
            check("b_err", {63'h0, err_b}, {63'h0, err_exp});
            for (int w = 0; w < WARM_B; w++) begin
                check("b_warm_busy",  {63'h0, busy_b},           64'h1);
                check("b_warm_ready", {63'h0, bus_b.seed_ready}, 64'h0);
                check("b_warm_valid", {63'h0, bus_b.rand_valid}, 64'h0);
                bus_b.seed_valid = 1'($urandom_range(0, 1));
                bus_b.seed_word  = 16'($urandom);
                bus_b.rand_ready = 1'($urandom_range(0, 1));
                @(negedge clock_0);
            end
            bus_b.seed_valid = 1'b0;
            check("b_entry_busy",  {63'h0, busy_b},           64'h0);
            check("b_entry_valid", {63'h0, bus_b.rand_valid}, 64'h0);
            @(negedge clock_0);
            cur = WARM_B + 1;
            for (int c = 0; c < 25; c++) begin
                check("b_run_valid", {63'h0, bus_b.rand_valid}, 64'h1);
                check("b_run_word",  64'(bus_b.rand_out), 64'(ref_word(seed, cur)));
                rdy = 1'($urandom_range(0, 1));
                bus_b.rand_ready = rdy;
                @(negedge clock_0);
                if (rdy) cur++;
            end
            hold = ref_word(seed, cur);
        end
        check("b_err_final", {63'h0, err_b}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
